// File: rtl/fl_chan_pkg.sv
// Shared constants for the FX2LP channel FIFO endpoint.
// FL_CHAN_FIFO_STALL_CNT_EN adds a third status byte (RX-full stall counter).
package fl_chan_pkg;

  localparam int unsigned STAT_RX_CNT = 0;
  localparam int unsigned STAT_TX_CNT = 1;
  localparam int unsigned STAT_STALL  = 2;

  localparam int unsigned CTL_FLUSH_RX  = 0;
  localparam int unsigned CTL_FLUSH_TX  = 1;
  localparam int unsigned CTL_CLR_STALL = 2;

  localparam logic [6:0] DEF_CHAN_DATA   = 7'd0;
  localparam logic [6:0] DEF_CHAN_STATUS = 7'd1;

`ifdef FL_CHAN_FIFO_STALL_CNT_EN
  localparam int unsigned STAT_NUM = 3;
`else
  localparam int unsigned STAT_NUM = 2;
`endif

endpackage

// File: rtl/fl_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; head is read
// combinationally from memory at the read pointer.
module fl_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  flush_in,
  input  logic                  push_in,
  input  logic [WIDTH-1:0]      push_data_in,
  input  logic                  pop_in,
  output logic [WIDTH-1:0]      pop_data_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic [DEPTH_LOG2:0]   count_out
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full_out     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_out    = (count_q == '0);
  assign count_out    = count_q;
  assign pop_data_out = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_in && !full_out;
    do_pop   = pop_in && !empty_out;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      if (do_push && !do_pop)      count_d = count_q + (DEPTH_LOG2+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !flush_in) mem_q[wr_ptr_q] <= push_data_in;
  end

endmodule

// File: rtl/fl_chan_fifo.sv
// FX2LP channel endpoint: data channel backed by RX/TX FIFOs, status channel
// with fill levels and flush control. FL_CHAN_FIFO_STALL_CNT_EN adds a stall counter.
module fl_chan_fifo
  import fl_chan_pkg::*;
#(
  parameter logic [6:0]  CHAN_DATA   = DEF_CHAN_DATA,
  parameter logic [6:0]  CHAN_STATUS = DEF_CHAN_STATUS,
  parameter int unsigned DEPTH_LOG2  = 4
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [6:0] chanAddr_in,
  input  logic [7:0] h2fData_in,
  input  logic       h2fValid_in,
  output logic       h2fReady_out,
  output logic [7:0] f2hData_out,
  output logic       f2hValid_out,
  input  logic       f2hReady_in,
  output logic [7:0] rxData_out,
  output logic       rxValid_out,
  input  logic       rxReady_in,
  input  logic [7:0] txData_in,
  input  logic       txValid_in,
  output logic       txReady_out
);

  logic                data_sel, stat_sel;
  logic                h2f_xfer, ctl_wr;
  logic                rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic                tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [7:0]          tx_head, stat_byte;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic [1:0]          idx_q, idx_d, idx_eff;
  logic [6:0]          chan_q, chan_d;

  always_comb begin
    data_sel = (chanAddr_in == CHAN_DATA);
    stat_sel = (chanAddr_in == CHAN_STATUS);

    h2fReady_out = data_sel ? !rx_full : 1'b1;
    h2f_xfer     = h2fValid_in && h2fReady_out;
    ctl_wr       = stat_sel && h2f_xfer;
    rx_push      = data_sel && h2f_xfer;
    rx_flush     = ctl_wr && h2fData_in[CTL_FLUSH_RX];
    tx_flush     = ctl_wr && h2fData_in[CTL_FLUSH_TX];
    rx_pop       = rxReady_in && !rx_empty;
    tx_push      = txValid_in && !tx_full;
    tx_pop       = data_sel && f2hReady_in && !tx_empty;

    rxValid_out = !rx_empty;
    txReady_out = !tx_full;
  end

  fl_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .flush_in     (rx_flush),
    .push_in      (rx_push),
    .push_data_in (h2fData_in),
    .pop_in       (rx_pop),
    .pop_data_out (rxData_out),
    .full_out     (rx_full),
    .empty_out    (rx_empty),
    .count_out    (rx_count)
  );

  fl_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .flush_in     (tx_flush),
    .push_in      (tx_push),
    .push_data_in (txData_in),
    .pop_in       (tx_pop),
    .pop_data_out (tx_head),
    .full_out     (tx_full),
    .empty_out    (tx_empty),
    .count_out    (tx_count)
  );

`ifdef FL_CHAN_FIFO_STALL_CNT_EN
  logic [7:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (ctl_wr && h2fData_in[CTL_CLR_STALL])
      stall_d = '0;
    else if (data_sel && h2fValid_in && rx_full && stall_q != '1)
      stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) stall_q <= '0;
    else          stall_q <= stall_d;
  end
`endif

  // A channel change is seen in the same cycle, so the first status read
  // after switching already returns byte 0.
  always_comb begin
    idx_eff = (chanAddr_in != chan_q) ? '0 : idx_q;
    chan_d  = chanAddr_in;

    stat_byte = 8'h00;
    if (idx_eff == 2'(STAT_RX_CNT))      stat_byte = 8'(rx_count);
    else if (idx_eff == 2'(STAT_TX_CNT)) stat_byte = 8'(tx_count);
`ifdef FL_CHAN_FIFO_STALL_CNT_EN
    else if (idx_eff == 2'(STAT_STALL))  stat_byte = stall_q;
`endif

    idx_d = idx_eff;
    if (stat_sel && f2hReady_in)
      idx_d = (idx_eff == 2'(STAT_NUM - 1)) ? '0 : idx_eff + 2'd1;

    if (data_sel) begin
      f2hValid_out = !tx_empty;
      f2hData_out  = tx_head;
    end else if (stat_sel) begin
      f2hValid_out = 1'b1;
      f2hData_out  = stat_byte;
    end else begin
      f2hValid_out = 1'b1;
      f2hData_out  = 8'h00;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      idx_q  <= '0;
      chan_q <= chanAddr_in;
    end else begin
      idx_q  <= idx_d;
      chan_q <= chan_d;
    end
  end

endmodule

// File: tb/tb_fl_chan_fifo.sv
// Scoreboard bench for fl_chan_fifo: queue-based reference model, directed
// scenarios followed by randomized channel traffic.
module tb_fl_chan_fifo;

  localparam int DL    = 2;
  localparam int DEPTH = 4;
`ifdef FL_CHAN_FIFO_STALL_CNT_EN
  localparam int NSTAT = 3;
`else
  localparam int NSTAT = 2;
`endif

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [6:0] chanAddr_in;
  logic [7:0] h2fData_in;
  logic       h2fValid_in;
  logic       h2fReady_out;
  logic [7:0] f2hData_out;
  logic       f2hValid_out;
  logic       f2hReady_in;
  logic [7:0] rxData_out;
  logic       rxValid_out;
  logic       rxReady_in;
  logic [7:0] txData_in;
  logic       txValid_in;
  logic       txReady_out;

  fl_chan_fifo #(.CHAN_DATA(7'd0), .CHAN_STATUS(7'd1), .DEPTH_LOG2(DL)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .chanAddr_in  (chanAddr_in),
    .h2fData_in   (h2fData_in),
    .h2fValid_in  (h2fValid_in),
    .h2fReady_out (h2fReady_out),
    .f2hData_out  (f2hData_out),
    .f2hValid_out (f2hValid_out),
    .f2hReady_in  (f2hReady_in),
    .rxData_out   (rxData_out),
    .rxValid_out  (rxValid_out),
    .rxReady_in   (rxReady_in),
    .txData_in    (txData_in),
    .txValid_in   (txValid_in),
    .txReady_out  (txReady_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: byte queues for the FIFOs, plus status index/stall state.
  byte unsigned rxq[$];
  byte unsigned txq[$];
  int   idx, eff, stall, rx_n, tx_n;
  int   exp_h2fr, exp_f2hv, exp_f2hd, exp_rxd;
  bit   h2f_x, f2h_x, started = 0;
  logic [6:0] prev_chan;

  always @(negedge clk_in) begin
    if (reset_in) begin
      rxq.delete();
      txq.delete();
      idx = 0;
      stall = 0;
      prev_chan = chanAddr_in;
      started = 1;
    end else if (started) begin
      rx_n = rxq.size();
      tx_n = txq.size();
      eff  = (chanAddr_in != prev_chan) ? 0 : idx;

      exp_h2fr = (chanAddr_in == 0) ? int'(rx_n < DEPTH) : 1;
      exp_f2hv = (chanAddr_in == 0) ? int'(tx_n != 0) : 1;
      if (chanAddr_in == 0)      exp_f2hd = (tx_n != 0) ? int'(txq[0]) : 0;
      else if (chanAddr_in == 1) exp_f2hd = (eff == 0) ? rx_n : (eff == 1) ? tx_n : stall;
      else                       exp_f2hd = 0;

      chk("h2f_ready", int'(h2fReady_out), exp_h2fr);
      chk("f2h_valid", int'(f2hValid_out), exp_f2hv);
      if (exp_f2hv != 0) chk("f2h_data", int'(f2hData_out), exp_f2hd);
      chk("rx_valid", int'(rxValid_out), int'(rx_n != 0));
      chk("tx_ready", int'(txReady_out), int'(tx_n < DEPTH));

      h2f_x = h2fValid_in && (exp_h2fr != 0);
      f2h_x = f2hReady_in && (exp_f2hv != 0);

      if (rxReady_in && rx_n != 0) begin
        exp_rxd = int'(rxq.pop_front());
        chk("rx_data", int'(rxData_out), exp_rxd);
      end
      if (chanAddr_in == 1 && h2f_x && h2fData_in[0]) rxq.delete();
      else if (chanAddr_in == 0 && h2f_x)             rxq.push_back(h2fData_in);

      if (chanAddr_in == 0 && f2h_x) void'(txq.pop_front());
      if (chanAddr_in == 1 && h2f_x && h2fData_in[1]) txq.delete();
      else if (txValid_in && tx_n < DEPTH)            txq.push_back(txData_in);

`ifdef FL_CHAN_FIFO_STALL_CNT_EN
      if (chanAddr_in == 1 && h2f_x && h2fData_in[2]) stall = 0;
      else if (chanAddr_in == 0 && h2fValid_in && rx_n == DEPTH && stall < 255) stall++;
`endif

      if (chanAddr_in == 1 && f2h_x) idx = (eff + 1) % NSTAT;
      else                           idx = eff;
      prev_chan = chanAddr_in;
    end
  end

  task automatic step(input int ch, input int hv, input int hd, input int fr,
                      input int rr, input int tv, input int td);
    chanAddr_in = 7'(ch);
    h2fValid_in = 1'(hv);
    h2fData_in  = 8'(hd);
    f2hReady_in = 1'(fr);
    rxReady_in  = 1'(rr);
    txValid_in  = 1'(tv);
    txData_in   = 8'(td);
    @(posedge clk_in);
    #1;
  endtask

  int ch_r;

  initial begin
    reset_in = 1'b1;
    chanAddr_in = '0; h2fValid_in = 0; h2fData_in = '0; f2hReady_in = 0;
    rxReady_in = 0; txValid_in = 0; txData_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    reset_in = 1'b0;

    // RX ordering
    step(0, 1, 'h11, 0, 0, 0, 0);
    step(0, 1, 'h22, 0, 0, 0, 0);
    step(0, 1, 'h33, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 1, 0, 0);

    // RX full back-pressure, fifth byte accepted after one pop
    for (int b = 1; b <= 4; b++) step(0, 1, b, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0, 0, 0);
    step(0, 1, 5, 0, 1, 0, 0);
    step(0, 1, 5, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 1, 0, 0);

    // TX to host
    step(0, 0, 0, 0, 0, 1, 'hA5);
    step(0, 0, 0, 0, 0, 1, 'h5A);
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);

    // Status reads with index wrap and restart on channel change
    step(0, 1, 1, 0, 0, 1, 'h77);
    step(0, 1, 2, 0, 0, 1, 'h78);
    step(0, 1, 3, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);

    // Flush both while user pushes TX in the same cycle
    step(1, 1, 3, 0, 0, 1, 'h99);
    step(1, 0, 0, 0, 0, 0, 0);

    // Mid-stream reset
    step(0, 1, 'hAB, 0, 0, 1, 'hCD);
    step(0, 1, 'hAC, 0, 0, 1, 'hCE);
    reset_in = 1'b1;
    step(0, 1, 'hAD, 0, 0, 1, 'hCF);
    reset_in = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);

    // Randomized traffic with sticky channel selection
    ch_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) ch_r = $urandom_range(0, 2);
      reset_in = ($urandom_range(0, 799) == 0);
      step(ch_r,
           (ch_r == 1) ? int'($urandom_range(0, 7) == 0) : int'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)));
    end
    reset_in = 1'b0;
    repeat (4) step(0, 0, 0, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fl_chan_fifo.md
Name: fl_chan_fifo

Overview:
Channel-side endpoint that sits directly downstream of the FX2LP comm block and consumes its channel read/write pipes (chanAddr, h2f, f2h).
- Buffers host writes to one data channel in an RX FIFO.
- Serves host reads of that channel from a TX FIFO.
- Exposes a status/control channel holding FIFO fill levels and flush controls.
- User logic sees two plain valid/ready byte streams.

Parameters:
CHAN_DATA, 7'd0, channel address of the data pipe
CHAN_STATUS, 7'd1, channel address of the status/control pipe; must differ from CHAN_DATA
DEPTH_LOG2, 4, log2 of each FIFO depth; legal range 1..7

Ports:
clk_in  in  1  48MHz system clock, same clock as the comm block
reset_in  in  1  synchronous reset, active-high
chanAddr_in  in  7  currently selected channel
h2fData_in  in  8  host-to-FPGA data byte
h2fValid_in  in  1  comm block offers h2f byte this cycle
h2fReady_out  out  1  block accepts h2f byte this cycle
f2hData_out  out  8  FPGA-to-host data byte
f2hValid_out  out  1  f2hData_out valid this cycle
f2hReady_in  in  1  comm block takes f2h byte this cycle
rxData_out  out  8  head of RX FIFO
rxValid_out  out  1  RX FIFO not empty
rxReady_in  in  1  user pops RX head
txData_in  in  8  user byte for host
txValid_in  in  1  user offers TX byte
txReady_out  out  1  TX FIFO not full

Behaviour:
Reset and transfer rules
- Reset (synchronous, any time, including mid-transfer): both FIFO pointers and counts go to 0 and the status byte index goes to 0. Outputs after reset: rxValid_out=0, txReady_out=1, f2hValid_out=0 when CHAN_DATA is selected, h2fReady_out=1 unless RX is full.
- A transfer happens on a rising edge when valid&&ready.

FIFOs (two instances, first-word-fall-through)
- Storage: memory plus count of DEPTH_LOG2+1 bits; pointers wrap modulo 2^DEPTH_LOG2.
- full = (count == 2^DEPTH_LOG2); empty = (count == 0).
- Push when full is impossible because ready is gated by !full; there is no bypass path.
- Simultaneous push and pop: count unchanged, both pointers advance.
- A byte pushed at edge N is visible at the FIFO head in cycle N+1 (1-cycle latency); the head is combinational from memory at the read pointer.

h2f side
- chanAddr_in==CHAN_DATA: h2fReady_out = !rxFull; accepted byte is pushed into RX.
- chanAddr_in==CHAN_STATUS: h2fReady_out=1; accepted byte is a control write.
  - bit0=1 flushes RX.
  - bit1=1 flushes TX.
  - Other bits are ignored.
  - Flush sets pointers and count to 0 at that edge and overrides any same-cycle user push or pop on the flushed FIFO.
- Any other channel: h2fReady_out=1 and the byte is discarded.

f2h side
- CHAN_DATA: f2hValid_out = !txEmpty; f2hData_out = TX head; a transfer pops TX.
- CHAN_STATUS: f2hValid_out=1; f2hData_out = status byte selected by index.
  - idx0 = zero-extended RX count.
  - idx1 = zero-extended TX count.
  - Each transfer advances idx; idx wraps after the last byte.
  - Counts are sampled combinationally in the cycle of transfer.
- Other channel: f2hValid_out=1, f2hData_out=8'h00.

Status index
- idx resets to 0 whenever chanAddr_in differs from its value in the previous cycle. A registered copy of chanAddr_in is kept for this.

User side
- rxValid_out = !rxEmpty; rxReady_in pops RX.
- txReady_out = !txFull; txValid_in pushes TX.

Optional Feature:
FL_CHAN_FIFO_STALL_CNT_EN
- Defined: adds an 8-bit saturating counter.
  - Increments each cycle in which chanAddr_in==CHAN_DATA, h2fValid_in=1 and RX is full.
  - Holds at 8'hFF.
  - Status read cycles through 3 bytes; idx2 = counter.
  - Control write bit2=1 clears the counter.
  - Reset clears the counter.
- Undefined: no counter; status cycles through 2 bytes; bit2 is ignored.

Decomposition:
- Package fl_chan_pkg:
  - status index localparams STAT_RX_CNT=0, STAT_TX_CNT=1, STAT_STALL=2.
  - control bit positions CTL_FLUSH_RX=0, CTL_FLUSH_TX=1, CTL_CLR_STALL=2.
  - default channel constants.
- Sub-module fl_sync_fifo (params WIDTH=8, DEPTH_LOG2), with ports clk_in, reset_in, flush_in, push/pop, data, full, empty, count. It is instantiated twice (RX, TX).

Test Plan:
- Reset, then chanAddr=0: host writes 0x11,0x22,0x33 (h2fValid=1, rxReady=0) -> rxValid_out rises 1 cycle after first accept; user pops in order 0x11,0x22,0x33; rxValid_out=0 afterwards.
- DEPTH_LOG2=2, host writes 5 bytes with rxReady=0 -> 4 accepted, h2fReady_out=0 on 5th; one user pop -> 5th accepted next edge; no data loss.
- User pushes 0xA5,0x5A into TX; host reads chanAddr=0 with f2hReady=1 -> f2h bytes 0xA5,0x5A, then f2hValid_out=0.
- RX holds 3 and TX holds 2; host reads chanAddr=1 for 3 bytes -> 0x03,0x02,0x03 (0x03,0x02,STALL with feature); switch to chanAddr=0 and back to 1 -> idx restarts, first byte 0x03.
- Host writes 0x03 to chanAddr=1 while user pushes TX in the same cycle -> both counts 0 next cycle; rxValid_out=0.
- Assert reset_in mid-stream with both FIFOs partly full -> next cycle counts 0, rxValid_out=0, txReady_out=1; stall counter (if enabled) 0.
